iqueue_param: RTL and testbench
===============================

# iqueue_param

Parametrised instruction queue between IFetch and the issue stage. It buffers fetched instructions with their PC and branch-prediction bit in a circular buffer of configurable depth and width, and presents the head entry through a valid/ready issue handshake. It also provides an occupancy count, an almost-full backpressure signal for IFetch, a single-cycle flush for branch mispredicts, and a sticky overflow flag.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_W, 4, log2(DEPTH); index width
- XLEN, 32, width of instruction word and PC
- AFULL_SLACK, 2, almost_full asserts when count ≥ DEPTH − AFULL_SLACK; range 1..DEPTH−1
- clk  in  1  the single clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state immediately when low
- rdy  in  1  global enable; when low, all state holds and pushes/pops are ignored
- flush  in  1  discard all entries (mispredict/redirect)
- inst_rdy  in  1  push strobe from IFetch
- inst  in  XLEN  instruction to push
- pc_in  in  XLEN  PC of pushed instruction
- pred_in  in  1  predicted-taken bit of pushed instruction
- almost_full  out  1  backpressure to IFetch
- full  out  1  count == DEPTH
- out_valid  out  1  head entry is valid (count ≠ 0)
- out_ready  in  1  issue stage consumes head this cycle
- out_inst  out  XLEN  head instruction; 0 when out_valid = 0
- out_pc  out  XLEN  head PC; 0 when out_valid = 0
- out_pred  out  1  head predicted-taken bit; 0 when out_valid = 0
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was attempted while full

## Operation
- State: head, tail (ADDR_W bits, wrap modulo DEPTH), count (ADDR_W+1 bits), overflow, plus storage arrays for inst, pc and pred. Storage is not reset.
- Full/empty come from count only. All DEPTH slots are usable; no slot is left unused.
- Effective strobes, all gated by rdy = 1:
  - push = inst_rdy && !full
  - pop = out_valid && out_ready
- Push: write {inst, pc_in, pred_in} at tail, then tail ← tail+1.
- Pop: head ← head+1.
- count ← count + push − pop. A simultaneous push and pop leaves count unchanged.
- full and empty are evaluated on the pre-edge count:
  - Push while full is dropped and sets overflow ← 1, even if a pop happens the same cycle.
  - Pop while empty is ignored. There is no empty bypass; a pushed entry is visible on out_* one cycle later.
- Flush (rdy = 1) has priority over push and pop in the same cycle: head ← 0, tail ← 0, count ← 0. A concurrent push is discarded and does not set overflow. overflow itself is not cleared by flush.
- overflow clears only on reset.
- out_inst, out_pc and out_pred are combinational reads of slot head, AND-gated with out_valid.
- almost_full = (count ≥ DEPTH − AFULL_SLACK), combinational from count.

## Timing
- Reset (rst low), asynchronously:
  - head = tail = 0, count = 0, overflow = 0
  - out_valid = 0, full = 0, almost_full = 0
  - out_inst = out_pc = 0, out_pred = 0
- Release of rst is synchronous to the clk edge; first push is possible on the first edge after rst goes high.
- Latency: push at edge N → out_valid = 1 and data on out_* after edge N (usable in cycle N+1).
- Pop handshake: entry leaves at the edge where out_valid && out_ready && rdy. The next entry, or out_valid = 0, is present after that edge. out_ready may be asserted without out_valid.
- Flush at edge N → out_valid = 0 and count = 0 after edge N.
- rdy low: no state changes, including flush; outputs hold their combinational values.
- Wrap: head and tail roll from DEPTH−1 to 0 with no bubble.
- Reset asserted mid-operation overrides everything immediately; in-flight push/pop are lost.

## Test plan
- Reset then idle: rst low → count = 0, out_valid = 0, out_inst = 0, out_pc = 0, full = 0, almost_full = 0.
- Fill (DEPTH = 16, AFULL_SLACK = 2): 16 pushes, inst = i, pc = 4i, out_ready = 0 → almost_full rises after the 14th push, full after the 16th, count = 16. A 17th push sets overflow = 1 and count stays 16.
- Drain in order after fill with out_ready = 1 → out_pc = 0, 4, …, 60 on consecutive cycles, then out_valid = 0.
- Wrap with simultaneous push/pop: 20 cycles of push and pop at count = 3 → count stays 3, ordering is preserved across the 15→0 wrap, and out_pc increments by 4 each cycle.
- Flush with concurrent push and pop at count = 5 → next cycle count = 0, out_valid = 0, out_inst = 0, overflow unchanged. A following push appears at out_pc one cycle later.
- rdy = 0 for 3 cycles with inst_rdy, out_ready and flush all high → count, out_pc and overflow are unchanged. Async reset pulsed mid-cycle → outputs go to reset values before the next edge.

Source files
------------

// File: rtl/iqueue_param.sv
// Circular instruction queue between fetch and issue.
// Head entry is presented through a valid/ready handshake.
module iqueue_param #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int XLEN        = 32,
  parameter int AFULL_SLACK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              inst_rdy,
  input  logic [XLEN-1:0]   inst,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              pred_in,
  output logic              almost_full,
  output logic              full,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_pred,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pred;
  } entry_t;

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT =
    (ADDR_W+1)'(DEPTH - AFULL_SLACK);

  entry_t            mem [DEPTH];
  entry_t            head_e;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              push;
  logic              pop;
  logic              drop;

  assign full        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);
  assign out_valid   = (count != '0);

  // Flush wins over both strobes and never flags overflow.
  assign push = rdy && !flush && inst_rdy && !full;
  assign pop  = rdy && !flush && out_valid && out_ready;
  assign drop = rdy && !flush && inst_rdy && full;

  assign head_e   = out_valid ? mem[head] : '0;
  assign out_inst = head_e.inst;
  assign out_pc   = head_e.pc;
  assign out_pred = head_e.pred;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{inst: inst, pc: pc_in, pred: pred_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (rdy) begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + ADDR_W'(1);
        end
        if (pop) begin
          head <= head + ADDR_W'(1);
        end
        count <= count + (ADDR_W+1)'(push)
                       - (ADDR_W+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_iqueue_param.sv
// Directed bench for iqueue_param: fill, drain,
// wrap, flush, stall and async reset.
module tb_iqueue_param;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              flush;
  logic              inst_rdy;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   pc_in;
  logic              pred_in;
  logic              almost_full;
  logic              full;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_inst;
  logic [XLEN-1:0]   out_pc;
  logic              out_pred;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  iqueue_param #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .XLEN(XLEN), .AFULL_SLACK(2)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .flush(flush), .inst_rdy(inst_rdy),
    .inst(inst), .pc_in(pc_in),
    .pred_in(pred_in),
    .almost_full(almost_full), .full(full),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .out_pred(out_pred), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    inst_rdy = 1'b0; inst = '0; pc_in = '0;
    pred_in = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_inst", out_inst, 0);
    check("rst_pc", out_pc, 0);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    @(negedge clk);
    rst = 1'b1;

    // pop on empty is ignored
    out_ready = 1'b1;
    step();
    check("empty_pop_cnt", count, 0);
    check("empty_pop_vld", out_valid, 0);
    out_ready = 1'b0;

    // fill
    inst_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inst = XLEN'(i);
      pc_in = XLEN'(4 * i);
      pred_in = i[0];
      step();
      check("fill_count", count, i + 1);
      check("fill_afull", almost_full, (i + 1 >= 14));
      check("fill_full", full, (i + 1 == 16));
    end
    check("fill_head_pc", out_pc, 0);
    check("fill_ovf0", overflow, 0);
    inst = 32'd16; pc_in = 32'd64;
    step();
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    check("ovf_head_pc", out_pc, 0);

    // drain
    inst_rdy = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_vld", out_valid, 1);
      check("drain_pc", out_pc, 4 * i);
      check("drain_inst", out_inst, i);
      check("drain_pred", out_pred, i % 2);
      step();
    end
    check("drain_vld_end", out_valid, 0);
    check("drain_cnt_end", count, 0);
    check("drain_inst_end", out_inst, 0);
    check("drain_pc_end", out_pc, 0);

    // wrap with simultaneous push/pop at count 3
    out_ready = 1'b0; inst_rdy = 1'b1;
    pred_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst = XLEN'(32'h100 + k);
      pc_in = XLEN'(32'h1000 + 4 * k);
      step();
    end
    check("wrap_pre_cnt", count, 3);
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      check("wrap_pc", out_pc, 32'h1000 + 4 * j);
      inst = XLEN'(32'h100 + 3 + j);
      pc_in = XLEN'(32'h1000 + 4 * (3 + j));
      step();
      check("wrap_cnt", count, 3);
    end
    check("wrap_pc_end", out_pc, 32'h1000 + 80);
    check("wrap_inst_end", out_inst, 32'h100 + 20);

    // flush at count 5 with push and pop
    out_ready = 1'b0;
    for (int k = 23; k < 25; k++) begin
      inst = XLEN'(32'h100 + k);
      pc_in = XLEN'(32'h1000 + 4 * k);
      step();
    end
    check("pre_flush_cnt", count, 5);
    flush = 1'b1; out_ready = 1'b1;
    inst = 32'hDEAD; pc_in = 32'hBEEF;
    step();
    flush = 1'b0; inst_rdy = 1'b0;
    out_ready = 1'b0;
    check("flush_cnt", count, 0);
    check("flush_vld", out_valid, 0);
    check("flush_inst", out_inst, 0);
    check("flush_ovf", overflow, 1);
    inst_rdy = 1'b1; inst = 32'hABC;
    pc_in = 32'h2000; pred_in = 1'b1;
    step();
    inst_rdy = 1'b0;
    check("post_flush_pc", out_pc, 32'h2000);
    check("post_flush_pred", out_pred, 1);
    check("post_flush_cnt", count, 1);

    // stall with everything asserted
    rdy = 1'b0; inst_rdy = 1'b1;
    out_ready = 1'b1; flush = 1'b1;
    inst = 32'h55; pc_in = 32'h3000;
    for (int j = 0; j < 3; j++) begin
      step();
      check("stall_cnt", count, 1);
      check("stall_pc", out_pc, 32'h2000);
      check("stall_ovf", overflow, 1);
    end
    rdy = 1'b1; inst_rdy = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    step();
    check("unstall_cnt", count, 1);

    // async reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("arst_cnt", count, 0);
    check("arst_vld", out_valid, 0);
    check("arst_ovf", overflow, 0);
    check("arst_pc", out_pc, 0);
    check("arst_pred", out_pred, 0);
    check("arst_afull", almost_full, 0);
    #1;
    rst = 1'b1;
    inst_rdy = 1'b1; inst = 32'h77;
    pc_in = 32'h4000; pred_in = 1'b0;
    step();
    inst_rdy = 1'b0;
    check("after_rst_pc", out_pc, 32'h4000);
    check("after_rst_cnt", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
